// File: rtl/proc_io_bridge.sv
// ============================================================================
//  Module   : proc_io_bridge
//  Brief    : Processor I/O bridge. One input FIFO feeds a zero-latency
//             processor read port; two FWFT output FIFOs capture processor
//             writes. Define PROC_IO_BRIDGE_ERR_EN for sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_io_bridge #(
    parameter int NBITS_IN  = 23,
    parameter int NBITS_OUT = 32,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // external source -> input FIFO
    input  logic [NBITS_IN-1:0]  s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    // processor side
    input  logic                 proc_req_in,
    output logic [NBITS_IN-1:0]  proc_io_in,
    input  logic [NBITS_OUT-1:0] proc_io_out,
    input  logic [1:0]           proc_out_en,
    // output FIFOs -> external sinks
    output logic [NBITS_OUT-1:0] m0_data,
    output logic                 m0_valid,
    input  logic                 m0_ready,
    output logic [NBITS_OUT-1:0] m1_data,
    output logic                 m1_valid,
    input  logic                 m1_ready,
    // error flags
    input  logic                 err_clr,
    output logic                 underflow,
    output logic                 overflow
);

    localparam int              c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_cw   = c_aw + 1;
    localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [NBITS_IN-1:0] r_in_mem [DEPTH];
    logic [c_aw-1:0]     r_in_wr;
    logic [c_aw-1:0]     r_in_rd;
    logic [c_cw-1:0]     r_in_cnt;
    logic                r_in_live;
    logic                w_in_full;
    logic                w_in_empty;
    logic                w_in_push;
    logic                w_in_pop;
    logic                w_uflow_evt;

    assign w_in_full   = (r_in_cnt == c_full);
    assign w_in_empty  = (r_in_cnt == '0);
    // r_in_live holds s_ready low through reset and up to the first edge after it
    assign s_ready     = r_in_live & ~w_in_full;
    assign w_in_push   = s_valid & s_ready;
    assign w_in_pop    = proc_req_in & ~w_in_empty;
    assign w_uflow_evt = proc_req_in & w_in_empty;
    assign proc_io_in  = w_in_pop ? r_in_mem[r_in_rd] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wr   <= '0;
            r_in_rd   <= '0;
            r_in_cnt  <= '0;
            r_in_live <= 1'b0;
        end else begin
            r_in_live <= 1'b1;
            if (w_in_push) begin
                r_in_wr <= r_in_wr + c_aw'(1);
            end
            if (w_in_pop) begin
                r_in_rd <= r_in_rd + c_aw'(1);
            end
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + c_cw'(1);
                2'b01:   r_in_cnt <= r_in_cnt - c_cw'(1);
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFOs: index 0 is port address 1, index 1 is port address 2
    // ------------------------------------------------------------------
    logic [NBITS_OUT-1:0] w_m_data [2];
    logic [1:0]           w_m_valid;
    logic [1:0]           w_m_ready;
    logic [1:0]           w_oflow_evt;

    assign w_m_ready = {m1_ready, m0_ready};

    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        logic [NBITS_OUT-1:0] r_mem [DEPTH];
        logic [c_aw-1:0]      r_wr;
        logic [c_aw-1:0]      r_rd;
        logic [c_cw-1:0]      r_cnt;
        logic                 w_cap;
        logic                 w_full;
        logic                 w_push;
        logic                 w_pop;

        assign w_cap  = (proc_out_en == 2'(gi + 1));
        // fullness is pre-edge: a same-cycle pop does not make room
        assign w_full = (r_cnt == c_full);
        assign w_push = w_cap & ~w_full;
        assign w_pop  = w_m_valid[gi] & w_m_ready[gi];

        assign w_oflow_evt[gi] = w_cap & w_full;
        assign w_m_valid[gi]   = (r_cnt != '0);
        assign w_m_data[gi]    = r_mem[r_rd];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + c_aw'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + c_aw'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + c_cw'(1);
                    2'b01:   r_cnt <= r_cnt - c_cw'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr] <= proc_io_out;
            end
        end
    end

    assign m0_data  = w_m_data[0];
    assign m1_data  = w_m_data[1];
    assign m0_valid = w_m_valid[0];
    assign m1_valid = w_m_valid[1];

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef PROC_IO_BRIDGE_ERR_EN
    logic r_uflow;
    logic r_oflow;

    // a new event in the clear cycle keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uflow <= 1'b0;
            r_oflow <= 1'b0;
        end else begin
            if (w_uflow_evt) begin
                r_uflow <= 1'b1;
            end else if (err_clr) begin
                r_uflow <= 1'b0;
            end
            if (|w_oflow_evt) begin
                r_oflow <= 1'b1;
            end else if (err_clr) begin
                r_oflow <= 1'b0;
            end
        end
    end

    assign underflow = r_uflow;
    assign overflow  = r_oflow;
`else
    logic w_unused_err;

    assign w_unused_err = ^{err_clr, w_uflow_evt, w_oflow_evt};
    assign underflow    = 1'b0;
    assign overflow     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
// ============================================================================
//  Module   : tb_proc_io_bridge
//  Brief    : Scoreboard bench for proc_io_bridge (honours PROC_IO_BRIDGE_ERR_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_io_bridge;

    localparam int NBITS_IN  = 23;
    localparam int NBITS_OUT = 32;
    localparam int DEPTH     = 16;
`ifdef PROC_IO_BRIDGE_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NBITS_IN-1:0]  s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 proc_req_in;
    logic [NBITS_IN-1:0]  proc_io_in;
    logic [NBITS_OUT-1:0] proc_io_out;
    logic [1:0]           proc_out_en;
    logic [NBITS_OUT-1:0] m0_data;
    logic                 m0_valid;
    logic                 m0_ready;
    logic [NBITS_OUT-1:0] m1_data;
    logic                 m1_valid;
    logic                 m1_ready;
    logic                 err_clr;
    logic                 underflow;
    logic                 overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [NBITS_IN-1:0]  q_in [$];
    logic [NBITS_OUT-1:0] q_m0 [$];
    logic [NBITS_OUT-1:0] q_m1 [$];

    proc_io_bridge #(
        .NBITS_IN  (NBITS_IN),
        .NBITS_OUT (NBITS_OUT),
        .DEPTH     (DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .proc_req_in (proc_req_in),
        .proc_io_in  (proc_io_in),
        .proc_io_out (proc_io_out),
        .proc_out_en (proc_out_en),
        .m0_data     (m0_data),
        .m0_valid    (m0_valid),
        .m0_ready    (m0_ready),
        .m1_data     (m1_data),
        .m1_valid    (m1_valid),
        .m1_ready    (m1_ready),
        .err_clr     (err_clr),
        .underflow   (underflow),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic [NBITS_IN-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        q_in.push_back(d);
        step();
        s_valid = 1'b0;
    endtask

    // strobe one processor read and compare against the scoreboard
    task automatic pop_in(input string tag);
        logic [NBITS_IN-1:0] exp;
        exp = (q_in.size() != 0) ? q_in.pop_front() : '0;
        proc_req_in = 1'b1;
        #1;
        chk(tag, 64'(proc_io_in), 64'(exp));
        step();
        proc_req_in = 1'b0;
    endtask

    task automatic capture(input logic [1:0] addr, input logic [NBITS_OUT-1:0] d);
        proc_out_en = addr;
        proc_io_out = d;
        if (addr == 2'd1 && q_m0.size() < DEPTH) q_m0.push_back(d);
        if (addr == 2'd2 && q_m1.size() < DEPTH) q_m1.push_back(d);
        step();
        proc_out_en = 2'd0;
    endtask

    task automatic drain_out(input int idx);
        logic [NBITS_OUT-1:0] exp;
        while ((idx == 0 ? q_m0.size() : q_m1.size()) != 0) begin
            exp = (idx == 0) ? q_m0.pop_front() : q_m1.pop_front();
            chk(idx == 0 ? "m0_valid" : "m1_valid", 64'(idx == 0 ? m0_valid : m1_valid), 64'(1));
            chk(idx == 0 ? "m0_data" : "m1_data", 64'(idx == 0 ? m0_data : m1_data), 64'(exp));
            if (idx == 0) m0_ready = 1'b1; else m1_ready = 1'b1;
            step();
            m0_ready = 1'b0;
            m1_ready = 1'b0;
        end
        chk(idx == 0 ? "m0_empty" : "m1_empty", 64'(idx == 0 ? m0_valid : m1_valid), 64'(0));
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_cleared", 64'({underflow, overflow}), 64'(0));
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; proc_req_in = 1'b1;
        proc_io_out = '0; proc_out_en = 2'd0; m0_ready = 1'b0; m1_ready = 1'b0;
        err_clr = 1'b0;
        #12;
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_valids", 64'({m0_valid, m1_valid}), 64'(0));
        chk("rst_flags", 64'({underflow, overflow}), 64'(0));
        chk("rst_proc_io_in", 64'(proc_io_in), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        proc_req_in = 1'b0;
        step();
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));

        // ordered reads of signed samples, zero outside strobes
        push_in(NBITS_IN'(5));
        push_in(NBITS_IN'(-3));
        push_in(NBITS_IN'(7));
        for (int i = 0; i < 3; i++) begin
            chk("idle_io_in", 64'(proc_io_in), 64'(0));
            pop_in("read_seq");
            step();
        end
        chk("idle_io_in_end", 64'(proc_io_in), 64'(0));

        // underflow on empty read
        pop_in("underflow_read");
        chk("underflow_set", 64'(underflow), 64'(ERR_ON));
        clear_err();

        // push into empty not visible to same-cycle pop
        s_valid = 1'b1; s_data = NBITS_IN'(9); proc_req_in = 1'b1;
        #1;
        chk("same_cycle_push_pop", 64'(proc_io_in), 64'(0));
        step();
        s_valid = 1'b0; proc_req_in = 1'b0;
        q_in.push_back(NBITS_IN'(9));
        pop_in("late_read");
        clear_err();

        // fill input FIFO, then simultaneous push + pop only pops
        for (int i = 0; i < DEPTH; i++) push_in(NBITS_IN'($urandom));
        chk("full_s_ready", 64'(s_ready), 64'(0));
        s_valid = 1'b1; s_data = NBITS_IN'(23'h123456);
        pop_in("full_pop");
        s_valid = 1'b0;
        chk("after_pop_s_ready", 64'(s_ready), 64'(1));
        while (q_in.size() != 0) pop_in("drain_in");
        pop_in("blocked_word_absent");
        clear_err();

        // output capture by address, bit-exact, one-cycle latency
        capture(2'd1, 32'h7FFF_FFFF);
        chk("m0_latency", 64'(m0_valid), 64'(1));
        capture(2'd2, 32'h8000_0000);
        capture(2'd3, 32'h0000_0001);
        capture(2'd0, 32'h0000_0002);
        drain_out(0);
        drain_out(1);

        // overflow: DEPTH+1 writes with sink stalled
        for (int i = 0; i <= DEPTH; i++) capture(2'd1, $urandom);
        chk("overflow_set", 64'(overflow), 64'(ERR_ON));
        drain_out(0);
        clear_err();

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) push_in(NBITS_IN'($urandom));
        capture(2'd1, $urandom);
        capture(2'd1, $urandom);
        capture(2'd2, $urandom);
        capture(2'd2, $urandom);
        proc_req_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valids", 64'({m0_valid, m1_valid}), 64'(0));
        chk("async_rst_s_ready", 64'(s_ready), 64'(0));
        chk("async_rst_io_in", 64'(proc_io_in), 64'(0));
        q_in.delete(); q_m0.delete(); q_m1.delete();
        proc_req_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("rerst_s_ready", 64'(s_ready), 64'(1));
        chk("rerst_valids", 64'({m0_valid, m1_valid}), 64'(0));
        proc_req_in = 1'b1;
        #1;
        chk("rerst_in_empty", 64'(proc_io_in), 64'(0));
        proc_req_in = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
